// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - masked channel scan of an 8:1 mux into a byte with valid/ready output
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    scan request, only looked at while idle
//   mask     channel enable mask, captured when a scan is accepted
//   s        mux select, registered
//   mux_in   mux output for the currently selected channel
//   data     last completed scan result (masked-off channels read 0)
//   valid    data holds a result not yet accepted downstream
//   ready    downstream accepts data
//   busy     sequencer is not idle
module mux_scan_sequencer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] mask,
    output logic [2:0] s,
    input  logic       mux_in,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mask_q;
    logic [7:0] shadow;
    logic [7:0] shadow_final;
    logic [3:0] cnt;
    logic [2:0] first_idx;
    logic [2:0] next_idx;
    logic       has_next;
    logic       sample_now;

    // Lowest enabled channel of the incoming mask; scanning downward lets the
    // lowest set bit win.
    always_comb begin
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) first_idx = 3'(i);
        end
    end

    // Lowest enabled channel strictly above the current select.
    always_comb begin
        next_idx = s;
        has_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(s))) begin
                next_idx = 3'(i);
                has_next = 1'b1;
            end
        end
    end

    assign sample_now = (state == ST_SETTLE) && (cnt == 4'd0);

    // The final byte must include the sample taken on the same edge.
    always_comb begin
        shadow_final    = shadow;
        shadow_final[s] = mux_in;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (mask != 8'd0) ? ST_SETTLE : ST_DONE;
                end
            end
            ST_SETTLE: begin
                if (sample_now && !has_next) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        valid = (state == ST_DONE);
        busy  = (state != ST_IDLE);
    end

    // Datapath: select, settle counter, shadow byte and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= 3'd0;
            data   <= 8'd0;
            mask_q <= 8'd0;
            shadow <= 8'd0;
            cnt    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mask != 8'd0) begin
                            mask_q <= mask;
                            shadow <= 8'd0;
                            s      <= first_idx;
                            cnt    <= SETTLE_LOAD;
                        end else begin
                            data <= 8'd0;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        shadow[s] <= mux_in;
                        if (has_next) begin
                            s   <= next_idx;
                            cnt <= SETTLE_LOAD;
                        end else begin
                            data <= shadow_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
